// File: rtl/reg_wb_arbiter.sv
// Round-robin arbiter sharing one register-file write port between the ALU (A)
// and load (M) write-back paths, with optional suppression of writes to register 0.
module reg_wb_arbiter #(
  parameter bit ZERO_DROP = 1'b1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Hold,
  input  logic        ReqA,
  input  logic [4:0]  AddrA,
  input  logic [31:0] DataA,
  input  logic        ReqM,
  input  logic [4:0]  AddrM,
  input  logic [31:0] DataM,
  output logic        GntA,
  output logic        GntM,
  output logic        RegEn,
  output logic [4:0]  WriteRegister,
  output logic [31:0] WriteData,
  output logic [7:0]  DropCnt
);

  typedef enum logic {
    SRV_A = 1'b0,
    SRV_M = 1'b1
  } srv_e;

  srv_e        last_srv_r, last_srv_s;
  logic        gnt_a_r, gnt_a_s;
  logic        gnt_m_r, gnt_m_s;
  logic        reg_en_r, reg_en_s;
  logic [4:0]  wr_r, wr_s;
  logic [31:0] wd_r, wd_s;
  logic [7:0]  drop_cnt_r, drop_cnt_s;

  logic        elig_a_s, elig_m_s;
  logic        win_a_s, win_m_s;
  logic        grant_s, drop_s;
  logic [4:0]  win_addr_s;
  logic [31:0] win_data_s;

  // Arbitration and next-state computation for every registered output
  always_comb begin
    elig_a_s   = 1'b0;
    elig_m_s   = 1'b0;
    win_a_s    = 1'b0;
    win_m_s    = 1'b0;
    grant_s    = 1'b0;
    drop_s     = 1'b0;
    win_addr_s = AddrA;
    win_data_s = DataA;
    gnt_a_s    = 1'b0;
    gnt_m_s    = 1'b0;
    reg_en_s   = 1'b0;
    wr_s       = wr_r;
    wd_s       = wd_r;
    drop_cnt_s = drop_cnt_r;
    last_srv_s = last_srv_r;

    // A requester whose grant pulse is still high is masked to avoid a duplicate grant
    elig_a_s = ReqA && !Hold && !gnt_a_r;
    elig_m_s = ReqM && !Hold && !gnt_m_r;

    case ({elig_a_s, elig_m_s})
      2'b11: begin
        if (last_srv_r == SRV_A) begin
          win_m_s = 1'b1;
        end else begin
          win_a_s = 1'b1;
        end
      end
      2'b10:   win_a_s = 1'b1;
      2'b01:   win_m_s = 1'b1;
      default: begin
        win_a_s = 1'b0;
        win_m_s = 1'b0;
      end
    endcase

    grant_s = win_a_s || win_m_s;

    if (win_m_s) begin
      win_addr_s = AddrM;
      win_data_s = DataM;
    end else begin
      win_addr_s = AddrA;
      win_data_s = DataA;
    end

    drop_s  = grant_s && ZERO_DROP && (win_addr_s == 5'd0);
    gnt_a_s = win_a_s;
    gnt_m_s = win_m_s;

    if (grant_s) begin
      reg_en_s   = !drop_s;
      wr_s       = win_addr_s;
      wd_s       = win_data_s;
      last_srv_s = win_m_s ? SRV_M : SRV_A;
    end else begin
      reg_en_s   = 1'b0;
      wr_s       = wr_r;
      wd_s       = wd_r;
      last_srv_s = last_srv_r;
    end

    if (drop_s && (drop_cnt_r != 8'hFF)) begin
      drop_cnt_s = drop_cnt_r + 8'd1;
    end else begin
      drop_cnt_s = drop_cnt_r;
    end
  end

  // State register; reset leaves LastSrv at M so A wins the first tie
  always_ff @(posedge Clk) begin
    if (Rst) begin
      gnt_a_r    <= 1'b0;
      gnt_m_r    <= 1'b0;
      reg_en_r   <= 1'b0;
      wr_r       <= 5'd0;
      wd_r       <= 32'd0;
      drop_cnt_r <= 8'd0;
      last_srv_r <= SRV_M;
    end else begin
      gnt_a_r    <= gnt_a_s;
      gnt_m_r    <= gnt_m_s;
      reg_en_r   <= reg_en_s;
      wr_r       <= wr_s;
      wd_r       <= wd_s;
      drop_cnt_r <= drop_cnt_s;
      last_srv_r <= last_srv_s;
    end
  end

  assign GntA          = gnt_a_r;
  assign GntM          = gnt_m_r;
  assign RegEn         = reg_en_r;
  assign WriteRegister = wr_r;
  assign WriteData     = wd_r;
  assign DropCnt       = drop_cnt_r;

  reg_wb_arbiter_checker u_checker (
    .Clk     (Clk),
    .Rst     (Rst),
    .GntA    (GntA),
    .GntM    (GntM),
    .RegEn   (RegEn),
    .DropCnt (DropCnt)
  );

endmodule

// Protocol invariants of the arbiter outputs.
module reg_wb_arbiter_checker (
  input logic       Clk,
  input logic       Rst,
  input logic       GntA,
  input logic       GntM,
  input logic       RegEn,
  input logic [7:0] DropCnt
);

  logic       gnt_a_prev_r;
  logic       gnt_m_prev_r;
  logic [7:0] drop_prev_r;

  // Previous-cycle copies used to check pulse width and counter steps
  always_ff @(posedge Clk) begin
    if (Rst) begin
      gnt_a_prev_r <= 1'b0;
      gnt_m_prev_r <= 1'b0;
      drop_prev_r  <= 8'd0;
    end else begin
      gnt_a_prev_r <= GntA;
      gnt_m_prev_r <= GntM;
      drop_prev_r  <= DropCnt;
    end
  end

  a_one_grant: assert property (@(posedge Clk) disable iff (Rst) !(GntA && GntM));
  a_regen_needs_grant: assert property (@(posedge Clk) disable iff (Rst) (!RegEn || GntA || GntM));
  a_a_single_pulse: assert property (@(posedge Clk) disable iff (Rst) !(GntA && gnt_a_prev_r));
  a_m_single_pulse: assert property (@(posedge Clk) disable iff (Rst) !(GntM && gnt_m_prev_r));
  a_drop_step: assert property (@(posedge Clk) disable iff (Rst)
    ((DropCnt == drop_prev_r) || (DropCnt == drop_prev_r + 8'd1)));

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Scoreboard bench for reg_wb_arbiter: directed stimulus pushes expected grants,
// a forked monitor pops and compares them on every falling edge.
module tb_reg_wb_arbiter;

  logic        Clk = 1'b0;
  logic        Rst, Hold, ReqA, ReqM;
  logic [4:0]  AddrA, AddrM;
  logic [31:0] DataA, DataM;
  logic        GntA, GntM, RegEn;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic [7:0]  DropCnt;

  typedef struct packed {
    logic        src_m;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic        regen;
  } exp_t;

  exp_t        expq[$];
  logic [31:0] rf [32];
  int          checks = 0;
  int          failures = 0;

  reg_wb_arbiter #(.ZERO_DROP(1'b1)) dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .Hold          (Hold),
    .ReqA          (ReqA),
    .AddrA         (AddrA),
    .DataA         (DataA),
    .ReqM          (ReqM),
    .AddrM         (AddrM),
    .DataM         (DataM),
    .GntA          (GntA),
    .GntM          (GntM),
    .RegEn         (RegEn),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .DropCnt       (DropCnt)
  );

  always #5 Clk = ~Clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, got, want);
    end
  endtask

  task automatic expect_grant(input logic src_m, input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    e.src_m = src_m;
    e.wr    = a;
    e.wd    = d;
    e.regen = (a != 5'd0);
    expq.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge Clk);
      if (GntA || GntM) begin
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_grant: got GntA=%0b GntM=%0b want no grant", GntA, GntM);
        end else begin
          e = expq.pop_front();
          check("grant_src", {30'd0, GntA, GntM}, e.src_m ? 32'd1 : 32'd2);
          check("write_reg", {27'd0, WriteRegister}, {27'd0, e.wr});
          check("write_data", WriteData, e.wd);
          check("reg_en", {31'd0, RegEn}, {31'd0, e.regen});
        end
        if (RegEn) rf[WriteRegister] = WriteData;
      end else begin
        check("reg_en_idle", {31'd0, RegEn}, 32'd0);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnta"}, {31'd0, GntA}, 32'd0);
    check({tag, "_gntm"}, {31'd0, GntM}, 32'd0);
    check({tag, "_regen"}, {31'd0, RegEn}, 32'd0);
    check({tag, "_wr"}, {27'd0, WriteRegister}, 32'd0);
    check({tag, "_wd"}, WriteData, 32'd0);
    check({tag, "_dropcnt"}, {24'd0, DropCnt}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    Rst = 1'b1; Hold = 1'b0;
    ReqA = 1'b0; AddrA = 5'd0; DataA = 32'd0;
    ReqM = 1'b0; AddrM = 5'd0; DataM = 32'd0;
    fork
      monitor();
    join_none
    tick(2);
    check_reset_outputs("reset");

    // Both requesting continuously: A first, then strict alternation
    Rst = 1'b0;
    ReqA = 1'b1; AddrA = 5'd5; DataA = 32'h1111_1111;
    ReqM = 1'b1; AddrM = 5'd6; DataM = 32'h2222_2222;
    for (int i = 0; i < 3; i++) begin
      expect_grant(1'b0, 5'd5, 32'h1111_1111);
      expect_grant(1'b1, 5'd6, 32'h2222_2222);
    end
    tick(6);
    ReqA = 1'b0; ReqM = 1'b0;
    tick(1);
    check("alt_queue_left", expq.size(), 32'd0);
    check("alt_rf5", rf[5], 32'h1111_1111);

    // A alone held for six cycles: grant every second cycle
    ReqA = 1'b1; AddrA = 5'd3; DataA = 32'h3333_3333;
    repeat (3) expect_grant(1'b0, 5'd3, 32'h3333_3333);
    tick(6);
    ReqA = 1'b0;
    tick(1);
    check("aonly_queue_left", expq.size(), 32'd0);

    // Same address after LastSrv=A: M then A, A's data wins
    ReqA = 1'b1; AddrA = 5'd7; DataA = 32'h0000_000A;
    ReqM = 1'b1; AddrM = 5'd7; DataM = 32'h0000_000B;
    expect_grant(1'b1, 5'd7, 32'h0000_000B);
    expect_grant(1'b0, 5'd7, 32'h0000_000A);
    tick(2);
    ReqA = 1'b0; ReqM = 1'b0;
    tick(1);
    check("same_addr_queue_left", expq.size(), 32'd0);
    check("same_addr_rf7", rf[7], 32'h0000_000A);

    // Hold for three cycles blocks everything; then round-robin winner (M)
    Hold = 1'b1;
    ReqA = 1'b1; AddrA = 5'd8; DataA = 32'h8888_8888;
    ReqM = 1'b1; AddrM = 5'd9; DataM = 32'h9999_9999;
    tick(3);
    Hold = 1'b0;
    expect_grant(1'b1, 5'd9, 32'h9999_9999);
    expect_grant(1'b0, 5'd8, 32'h8888_8888);
    tick(2);
    ReqA = 1'b0; ReqM = 1'b0;
    tick(1);
    check("hold_queue_left", expq.size(), 32'd0);

    // Writes to register 0 are granted but dropped; counter saturates
    check("drop_before", {24'd0, DropCnt}, 32'd0);
    ReqM = 1'b1; AddrM = 5'd0; DataM = 32'hDEAD_BEEF;
    repeat (300) expect_grant(1'b1, 5'd0, 32'hDEAD_BEEF);
    tick(1);
    check("drop_first", {24'd0, DropCnt}, 32'd1);
    tick(599);
    ReqM = 1'b0;
    tick(1);
    check("drop_saturated", {24'd0, DropCnt}, 32'd255);
    check("drop_queue_left", expq.size(), 32'd0);
    check("drop_rf0", rf[0], 32'd0);

    // Reset while GntM is high, then A wins first again
    ReqA = 1'b1; AddrA = 5'd10; DataA = 32'hAAAA_0010;
    ReqM = 1'b1; AddrM = 5'd11; DataM = 32'hBBBB_0011;
    expect_grant(1'b0, 5'd10, 32'hAAAA_0010);
    expect_grant(1'b1, 5'd11, 32'hBBBB_0011);
    tick(2);
    check("midrst_gntm_high", {31'd0, GntM}, 32'd1);
    Rst = 1'b1;
    tick(1);
    check_reset_outputs("midrst");
    Rst = 1'b0;
    expect_grant(1'b0, 5'd10, 32'hAAAA_0010);
    expect_grant(1'b1, 5'd11, 32'hBBBB_0011);
    tick(2);
    ReqA = 1'b0; ReqM = 1'b0;
    tick(1);
    check("midrst_queue_left", expq.size(), 32'd0);

    // LastSrv=A before reset must still give A the first tie afterwards
    ReqA = 1'b1; AddrA = 5'd12; DataA = 32'h0000_000C;
    expect_grant(1'b0, 5'd12, 32'h0000_000C);
    tick(1);
    ReqA = 1'b0;
    Rst = 1'b1;
    tick(1);
    Rst = 1'b0;
    ReqA = 1'b1;
    ReqM = 1'b1; AddrM = 5'd13; DataM = 32'h0000_000D;
    expect_grant(1'b0, 5'd12, 32'h0000_000C);
    expect_grant(1'b1, 5'd13, 32'h0000_000D);
    tick(2);
    ReqA = 1'b0; ReqM = 1'b0;
    tick(1);
    check("lastsrv_rst_queue_left", expq.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_wb_arbiter.md
REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
REQ-001 Parameter: ZERO_DROP, default 1, meaning: when 1, writes addressed to register 0 are granted but not performed.
REQ-002 Clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 Rst  input  1  reset; synchronous and active-high.
REQ-004 Hold  input  1  when high, no grant and no write issue this edge.
REQ-005 ReqA  input  1  ALU write-back request.
REQ-006 AddrA  input  5  ALU destination register.
REQ-007 DataA  input  32  ALU write data.
REQ-008 ReqM  input  1  memory-load write-back request.
REQ-009 AddrM  input  5  load destination register.
REQ-010 DataM  input  32  load write data.
REQ-011 GntA  output  1  registered one-cycle grant pulse to the ALU requester.
REQ-012 GntM  output  1  registered one-cycle grant pulse to the load requester.
REQ-013 RegEn  output  1  registered write enable to the register file write port.
REQ-014 WriteRegister  output  5  registered write address to the register file.
REQ-015 WriteData  output  32  registered write data to the register file.
REQ-016 DropCnt  output  8  saturating count of writes suppressed by ZERO_DROP.

Function
REQ-017 The block SHALL share the single register-file write port between requesters A and M, issuing at most one grant per edge.
REQ-018 Eligibility at an edge: ReqX high, Hold low, and GntX currently low; a requester with GntX high is masked for that edge, preventing a duplicate grant before it drops ReqX.
REQ-019 Exactly one eligible requester SHALL win that edge.
REQ-020 Both eligible: winner is the requester not recorded in the LastSrv register (round-robin); LastSrv updates to the winner on every grant.
REQ-021 On a grant edge: GntX=1 for the winner and 0 for the other; WriteRegister and WriteData load the winner's address and data; RegEn=1, unless ZERO_DROP=1 and the address is 0, in which case RegEn=0.
REQ-022 Latency: request sampled at edge k; grant pulse and register-file write strobe are both visible in cycle k..k+1; the register file commits on edge k+1.
REQ-023 No-grant edge (no eligible requester, or Hold high): GntA=GntM=0 and RegEn=0; WriteRegister and WriteData hold their previous values.
REQ-024 Requester protocol: ReqX, AddrX and DataX held stable until GntX is seen; ReqX deasserted or new data presented on the edge after GntX; a continuously held ReqX is treated as back-to-back requests, grantable every second cycle.
REQ-025 Throughput: with both requests continuously high and Hold low, grants SHALL strictly alternate A,M,A,M with RegEn high every cycle.
REQ-026 Same-address requests from A and M are serialized in grant order; the later grant's data is the final register value; no merging.
REQ-027 DropCnt increments by 1 on each grant with ZERO_DROP=1 and winner address 0, saturating at 255; it is unchanged otherwise.
REQ-028 Hold asserted while GntX is high does not cancel the already-issued pulse; it only blocks the next edge.

Reset
REQ-029 Rst high at an edge SHALL force GntA=0, GntM=0, RegEn=0, WriteRegister=0, WriteData=0, DropCnt=0, and LastSrv=M, so A wins the first tie.
REQ-030 Reset mid-operation SHALL discard any in-flight grant; requesters re-arbitrate from the post-reset state on the first edge with Rst low.

Verification
REQ-031 Reset, then ReqA=ReqM=1 with AddrA=5/DataA=0x11111111 and AddrM=6/DataM=0x22222222 held -> GntA first cycle (WR=5, WD=0x11111111, RegEn=1), then GntM (WR=6), then alternating; no idle cycles.
REQ-032 ReqA only, held high 6 cycles -> GntA high in alternate cycles (3 pulses), RegEn matching GntA, GntM always 0.
REQ-033 ReqM with AddrM=0, DataM=0xDEADBEEF, ZERO_DROP=1 -> GntM=1, RegEn=0, DropCnt 0->1; after 300 such grants DropCnt=255.
REQ-034 Both requesting with Hold=1 for 3 cycles, then Hold=0 -> no grants and RegEn=0 during Hold; first grant after release goes to the round-robin winner.
REQ-035 Both requesting AddrA=AddrM=7 with DataA=0xA, DataM=0xB, after LastSrv=A -> M granted first, A second; register 7 finally holds 0xA.
REQ-036 Rst asserted in the cycle GntM is high -> next cycle all outputs 0; with both still requesting, A is granted first after release.
